// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability qualifier,
// registered level plus rise/fall strobes and a saturating bounce counter.
module button_debouncer #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       clr,
    output logic       d,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    logic             s1;
    logic             s;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             d_n;
    logic             rise_n;
    logic             fall_n;
    logic             abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= btn;
            s  <= s1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE_LO: begin
                if (s) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                    abort   = 1'b1;
                end else if (cnt == LAST) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                    d_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                    abort   = 1'b1;
                end else if (cnt == LAST) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                    d_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE_LO;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so strobes align with d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            d     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            d     <= d_n;
            rise  <= rise_n;
            fall  <= fall_n;
            busy  <= (state_n == WAIT_HI) || (state_n == WAIT_LO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= 8'd0;
        end else if (clr) begin
            glitch_cnt <= 8'd0;
        end else if (abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

endmodule
